lcd_text_sequencer: RTL and testbench
=====================================

// Module: lcd_text_sequencer
// PURPOSE
//  Upstream driver for the byte-level LCD write controller (16x2 HD44780 panel).
//  - After reset, waits for panel power-up, then issues the init command list.
//  - Holds a 32-char screen buffer (2 lines x 16) that the host writes at any time.
//  - On each refresh request, streams both lines to the controller one byte at a time,
//    using its Start/Done handshake.
// PARAMETERS
//  PWRUP_CYC  750000  clocks idle after reset before first command (15 ms @ 50 MHz)
//  CMD_CYC    2000    clocks idle after Done for normal command/char (40 us)
//  CLR_CYC    100000  clocks idle after Done for clear-display 0x01 (2 ms)
//  CNT_W      20      delay counter width; must hold max(PWRUP_CYC,CLR_CYC)
// PORTS
//  iCLK         in   1  system clock
//  Reset        in   1  synchronous, active-high reset
//  iWr          in   1  host buffer write strobe (1 cycle per byte)
//  iAddr        in   5  buffer index: 0-15 = line 1, 16-31 = line 2
//  iChar        in   8  ASCII byte to store
//  iRefresh     in   1  request full-screen rewrite (pulse)
//  oReady       out  1  1 once the init list has completed; stays 1 until Reset
//  oBusy        out  1  1 while in power-up, init or refresh
//  oLCD_DATA    out  8  byte to controller iDATA
//  oLCD_RS      out  1  to controller iRS: 0 = command, 1 = character
//  oLCD_Start   out  1  to controller iStart; controller acts on the rising edge
//  iLCD_Done    in   1  from controller oDone (level; cleared by controller after Start edge)
// BEHAVIOUR
//  Reset (sync, any state): all outputs 0 except oBusy=1; buffer = 0x20 (space);
//   refresh-pending flag cleared; FSM -> PWRUP; delay counter = 0.
//  Top FSM:
//   PWRUP: count to PWRUP_CYC, then -> INIT.
//   INIT: send 0x38, 0x0C, 0x01, 0x06 with RS=0. After the last one, oReady=1 and
//    -> REFRESH automatically; the first refresh needs no host request.
//   IDLE: oBusy=0. If iRefresh or pending is set, clear pending and -> REFRESH.
//   REFRESH: send 34 transfers in order:
//    0x80 (RS=0), buf[0..15] (RS=1), 0xC0 (RS=0), buf[16..31] (RS=1); then -> IDLE.
//  Per-byte transfer (one byte at a time, strict order):
//   SETUP: drive DATA/RS; Start=0; 1 cycle. Buffer is read in this cycle.
//   PULSE: Start=1.
//   WCLR: hold Start=1 until iLCD_Done==0.
//    This absorbs a Done left high by the previous byte.
//   WDONE: hold Start=1 until iLCD_Done==1.
//   GAP: Start=0; wait CLR_CYC if byte was cmd 0x01, else CMD_CYC; transfer complete.
//   DATA and RS stay stable from SETUP through GAP.
//  Handshake timing: min 1 Start-low cycle between bytes. No timeout; a stuck Done
//   stalls the FSM until Reset.
//  Host port:
//   - iWr is accepted in every state; buf[iAddr] <= iChar at the next edge.
//   - A write in the same cycle as SETUP of that index: the old value is sent.
//   - A write after SETUP of that index appears on the next refresh.
//   - iRefresh while oBusy=1 (PWRUP, INIT or REFRESH) sets pending. Multiple requests
//     collapse to one. A pending refresh runs immediately after the current activity.
//   - iRefresh in IDLE starts the refresh the next cycle; oBusy=1 from that cycle.
//  Width rules:
//   - Delay counter is CNT_W bits, compared with >=, and reset to 0 at each delay start.
//   - The 6-bit transfer index runs 0..33; no wrap.
//  Reset mid-transfer: Start drops to 0 next cycle. The controller may complete its
//   current pulse; the sequencer ignores Done until PULSE of the first init byte.
// STRUCTURE
//  lcd_pkg:
//   - command constants: LCD_FUNC_SET 8'h38, LCD_DISP_ON 8'h0C, LCD_CLEAR 8'h01,
//     LCD_ENTRY 8'h06, LCD_LINE1 8'h80, LCD_LINE2 8'hC0;
//   - state encodings; LCD_COLS=16, LCD_ROWS=2.
//  Sub-module lcd_byte_xfer: owns the SETUP..GAP handshake and delay counter.
//   - Interface: req/byte/rs/long_gap in, ack out.
//   - The top holds the buffer, PWRUP/INIT/IDLE/REFRESH FSM, index and pending flag.
// TESTING (PWRUP_CYC=20, CMD_CYC=4, CLR_CYC=10; behavioural controller model,
//  Done 6 cycles after Start edge)
//  1 Reset release -> Start stays 0 for 20 cycles; bytes 38,0C,01,06 in order.
//    After 01 Done, gap is >=10 cycles. oReady rises after the 06 gap.
//  2 Auto refresh after init -> 34 bytes: 80, 16x 0x20 RS=1, C0, 16x 0x20 RS=1.
//    Then oBusy=0.
//  3 Write 'H'@0, 'i'@17, then iRefresh in IDLE -> stream byte 2 = 0x48 and
//    byte 20 = 0x69; all others 0x20.
//  4 iRefresh pulsed 3 times during a refresh -> exactly one extra 34-byte refresh,
//    then IDLE.
//  5 Model holds Done=1 across Start edges; check each Start high persists through
//    Done low->high. DATA/RS are never changed while Start=1.
//  6 Reset asserted in the middle of byte 10 of a refresh -> next cycle Start=0,
//    oReady=0, oBusy=1; power-up wait and init list restart from 0x38.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the init command table for the LCD text sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam int LCD_COLS    = 16;
  localparam int LCD_ROWS    = 2;
  localparam int INIT_LEN    = 4;
  // One set-address command per row plus every character of that row.
  localparam int REFRESH_LEN = LCD_ROWS * (LCD_COLS + 1);

  typedef enum logic [1:0] {
    SEQ_PWRUP,
    SEQ_INIT,
    SEQ_IDLE,
    SEQ_REFRESH
  } seq_state_t;

  typedef enum logic [2:0] {
    XF_IDLE,
    XF_SETUP,
    XF_PULSE,
    XF_WCLR,
    XF_WDONE,
    XF_GAP
  } xfer_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    case (i)
      2'd0:    c = LCD_FUNC_SET;
      2'd1:    c = LCD_DISP_ON;
      2'd2:    c = LCD_CLEAR;
      default: c = LCD_ENTRY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_text_sequencer_if.sv
// Host buffer port plus the byte-level link to the LCD write controller.
// Latency: n/a (signal bundle only).
// Backpressure: controller link is Start/Done; host writes are never refused.
interface lcd_text_sequencer_if;
  logic       iWr;
  logic [4:0] iAddr;
  logic [7:0] iChar;
  logic       iRefresh;
  logic       oReady;
  logic       oBusy;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_Start;
  logic       iLCD_Done;

  // Sequencer side.
  modport master (
    input  iWr, iAddr, iChar, iRefresh, iLCD_Done,
    output oReady, oBusy, oLCD_DATA, oLCD_RS, oLCD_Start
  );

  // Host and controller side.
  modport slave (
    output iWr, iAddr, iChar, iRefresh, iLCD_Done,
    input  oReady, oBusy, oLCD_DATA, oLCD_RS, oLCD_Start
  );
endinterface

// File: rtl/lcd_byte_xfer.sv
// Pushes one byte through the controller Start/Done handshake, then waits out the settle gap.
// Latency: SETUP 1 + PULSE 1 + Done wait + gap of CMD_CYC+1 (CLR_CYC+1 for clear) cycles; ack on last gap cycle.
// Backpressure: caller holds req until ack; a Done that never toggles stalls here until reset.
module lcd_byte_xfer
  import lcd_pkg::*;
#(
  parameter int CMD_CYC = 2000,
  parameter int CLR_CYC = 100000,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] byte_val,
  input  logic       rs,
  input  logic       long_gap,
  input  logic       done,
  output logic       ack,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_start
);

  localparam logic [CNT_W-1:0] CMD_LIM = CNT_W'(CMD_CYC);
  localparam logic [CNT_W-1:0] CLR_LIM = CNT_W'(CLR_CYC);

  xfer_state_t      state, state_nxt;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             long_q;
  logic [CNT_W-1:0] cnt;

  // State register, byte capture at the end of SETUP, and the gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= XF_IDLE;
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      long_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      // Capturing at the end of SETUP means a buffer write landing on that
      // same edge does not disturb the byte already on the bus.
      if (state == XF_SETUP) begin
        data_q <= byte_val;
        rs_q   <= rs;
        long_q <= long_gap;
      end
      if (state == XF_WDONE && done) begin
        cnt <= '0;
      end else if (state == XF_GAP) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Handshake sequencing: Start stays high from PULSE until Done has been seen low then high.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    lcd_start = 1'b0;
    lcd_data  = data_q;
    lcd_rs    = rs_q;
    case (state)
      XF_IDLE: begin
        if (req) state_nxt = XF_SETUP;
      end
      XF_SETUP: begin
        lcd_data  = byte_val;
        lcd_rs    = rs;
        state_nxt = XF_PULSE;
      end
      XF_PULSE: begin
        lcd_start = 1'b1;
        state_nxt = XF_WCLR;
      end
      XF_WCLR: begin
        // Done may still be high from the previous byte; wait for the
        // controller to acknowledge this edge by dropping it.
        lcd_start = 1'b1;
        if (!done) state_nxt = XF_WDONE;
      end
      XF_WDONE: begin
        lcd_start = 1'b1;
        if (done) state_nxt = XF_GAP;
      end
      XF_GAP: begin
        if (cnt >= (long_q ? CLR_LIM : CMD_LIM)) begin
          ack       = 1'b1;
          state_nxt = XF_IDLE;
        end
      end
      default: state_nxt = XF_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_text_sequencer.sv
// Power-up wait, init command list, then full-screen refreshes of a 2x16 character buffer.
// Latency: refresh starts the cycle after iRefresh in IDLE; each byte costs one lcd_byte_xfer round.
// Backpressure: paced by controller Done; refresh requests while busy collapse into one pending refresh.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 750000,
  parameter int CMD_CYC   = 2000,
  parameter int CLR_CYC   = 100000,
  parameter int CNT_W     = 20
) (
  input  logic                 iCLK,
  input  logic                 Reset,
  lcd_text_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] PWRUP_LIM = CNT_W'(PWRUP_CYC);
  localparam logic [5:0]       INIT_END  = 6'(INIT_LEN - 1);
  localparam logic [5:0]       LINE2_IDX = 6'(LCD_COLS + 1);
  localparam logic [5:0]       REF_END   = 6'(REFRESH_LEN - 1);

  seq_state_t       state, state_nxt;
  logic [5:0]       idx;
  logic [CNT_W-1:0] pwr_cnt;
  logic             pending;
  logic             ready;
  logic [7:0]       char_buf [LCD_ROWS*LCD_COLS];

  logic             req;
  logic             ack;
  logic [7:0]       byte_val;
  logic             rs;
  logic             long_gap;
  logic [4:0]       rd_addr;

  // Screen buffer: cleared to spaces on reset, host may write in any state.
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      for (int i = 0; i < LCD_ROWS*LCD_COLS; i++) char_buf[i] <= 8'h20;
    end else if (bus.iWr) begin
      char_buf[bus.iAddr] <= bus.iChar;
    end
  end

  // Top state, transfer index, power-up counter, ready and pending-refresh flags.
  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state   <= SEQ_PWRUP;
      idx     <= 6'd0;
      pwr_cnt <= '0;
      pending <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == SEQ_PWRUP) pwr_cnt <= pwr_cnt + CNT_W'(1);
      if (ack) begin
        if ((state == SEQ_INIT && idx == INIT_END) ||
            (state == SEQ_REFRESH && idx == REF_END)) begin
          idx <= 6'd0;
        end else begin
          idx <= idx + 6'd1;
        end
      end
      if (state == SEQ_INIT && ack && idx == INIT_END) ready <= 1'b1;
      // IDLE always consumes the pending request as it leaves for REFRESH.
      if (state == SEQ_IDLE) pending <= 1'b0;
      else if (bus.iRefresh) pending <= 1'b1;
    end
  end

  // Next-state and byte selection: init table in INIT, address commands and buffer in REFRESH.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    byte_val  = 8'h00;
    rs        = 1'b0;
    rd_addr   = 5'd0;
    case (state)
      SEQ_PWRUP: begin
        if (pwr_cnt >= PWRUP_LIM) state_nxt = SEQ_INIT;
      end
      SEQ_INIT: begin
        req      = 1'b1;
        byte_val = init_cmd(idx[1:0]);
        if (ack && idx == INIT_END) state_nxt = SEQ_REFRESH;
      end
      SEQ_IDLE: begin
        if (bus.iRefresh || pending) state_nxt = SEQ_REFRESH;
      end
      SEQ_REFRESH: begin
        req = 1'b1;
        if (idx == 6'd0) begin
          byte_val = LCD_LINE1;
        end else if (idx == LINE2_IDX) begin
          byte_val = LCD_LINE2;
        end else begin
          rs       = 1'b1;
          // Skip the one (line 1) or two (line 2) address commands ahead of this char.
          rd_addr  = (idx < LINE2_IDX) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
          byte_val = char_buf[rd_addr];
        end
        if (ack && idx == REF_END) state_nxt = SEQ_IDLE;
      end
      default: state_nxt = SEQ_PWRUP;
    endcase
  end

  assign long_gap   = !rs && (byte_val == LCD_CLEAR);
  assign bus.oReady = ready;
  assign bus.oBusy  = (state != SEQ_IDLE);

  lcd_byte_xfer #(
    .CMD_CYC (CMD_CYC),
    .CLR_CYC (CLR_CYC),
    .CNT_W   (CNT_W)
  ) u_xfer (
    .clk       (iCLK),
    .rst       (Reset),
    .req       (req),
    .byte_val  (byte_val),
    .rs        (rs),
    .long_gap  (long_gap),
    .done      (bus.iLCD_Done),
    .ack       (ack),
    .lcd_data  (bus.oLCD_DATA),
    .lcd_rs    (bus.oLCD_RS),
    .lcd_start (bus.oLCD_Start)
  );

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench for lcd_text_sequencer with a behavioural LCD controller model.
// Latency: n/a (testbench).
// Backpressure: controller model raises Done 6 cycles after each Start edge.
module tb_lcd_text_sequencer;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic done_m = 1'b0;

  always #5 clk = ~clk;

  lcd_text_sequencer_if bus();
  assign bus.iLCD_Done = done_m;

  lcd_text_sequencer #(
    .PWRUP_CYC (20),
    .CMD_CYC   (4),
    .CLR_CYC   (10),
    .CNT_W     (20)
  ) dut (
    .iCLK  (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor log, one entry per Start rising edge.
  logic [8:0] got_q [$];
  int         gap_q [$];
  int         rise_q[$];
  logic       rdy_q [$];

  logic       prev_start = 1'b0;
  logic [8:0] cur        = 9'h000;
  bit         seen_low   = 1'b0;
  int         low_cnt    = 0;
  int         stab_viol  = 0;
  int         hs_viol    = 0;
  int         falls      = 0;
  int         mcnt       = 0;
  bit         mact       = 1'b0;
  int         clr_at     = 1;

  // Monitor first (sees Done before the model updates it), then the controller model.
  always @(negedge clk) begin
    if (bus.oLCD_Start && !prev_start) begin
      cur = {bus.oLCD_RS, bus.oLCD_DATA};
      got_q.push_back(cur);
      gap_q.push_back(low_cnt);
      rise_q.push_back(cyc);
      rdy_q.push_back(bus.oReady);
      low_cnt  = 0;
      seen_low = 1'b0;
    end else if (bus.oLCD_Start) begin
      if ({bus.oLCD_RS, bus.oLCD_DATA} != cur) stab_viol++;
    end else begin
      low_cnt++;
      if (prev_start && !rst) begin
        falls++;
        if (!(seen_low && done_m)) hs_viol++;
      end
    end
    if (bus.oLCD_Start && !done_m) seen_low = 1'b1;
    if (bus.oLCD_Start && !prev_start) begin
      mcnt = 0;
      mact = 1'b1;
    end
    if (mact) begin
      mcnt++;
      if (mcnt == clr_at) done_m = 1'b0;
      if (mcnt == 6) begin
        done_m = 1'b1;
        mact   = 1'b0;
      end
    end
    prev_start = bus.oLCD_Start;
  end

  logic [7:0] exp_buf [32];

  function automatic logic [8:0] exp_at(input int i);
    if (i == 0)  return 9'h080;
    if (i == 17) return 9'h0C0;
    if (i < 17)  return {1'b1, exp_buf[i-1]};
    return {1'b1, exp_buf[i-2]};
  endfunction

  function automatic logic [8:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 9'h1FF;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gap_q.size()) ? gap_q[i] : -1;
  endfunction

  function automatic int rise_at(input int i);
    return (i < rise_q.size()) ? rise_q[i] : -1000;
  endfunction

  function automatic logic rdy_at(input int i);
    return (i < rdy_q.size()) ? rdy_q[i] : 1'bx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    gap_q.delete();
    rise_q.delete();
    rdy_q.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (got_q.size() < n) begin
      fails++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (bus.oBusy !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (bus.oBusy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: oBusy %b, required 0", name, bus.oBusy);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] c);
    bus.iAddr = a;
    bus.iChar = c;
    bus.iWr   = 1'b1;
    tick(1);
    bus.iWr   = 1'b0;
  endtask

  task automatic pulse_refresh();
    bus.iRefresh = 1'b1;
    tick(1);
    bus.iRefresh = 1'b0;
  endtask

  task automatic chk_stream(input int base, input string tag);
    for (int i = 0; i < 34; i++) chk($sformatf("%s_byte%0d", tag, i), got_at(base + i), exp_at(i));
  endtask

  task automatic chk_init(input int rel, input string tag);
    logic [8:0] init_exp [4];
    init_exp[0] = 9'h038;
    init_exp[1] = 9'h00C;
    init_exp[2] = 9'h001;
    init_exp[3] = 9'h006;
    chk({tag, "_pwrup_wait"}, (rise_at(0) - rel) >= 20, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_init%0d", tag, i), got_at(i), init_exp[i]);
    chk({tag, "_clr_gap"}, gap_at(3) >= 10, 1);
    chk({tag, "_rdy_before"}, rdy_at(3), 0);
    chk({tag, "_rdy_after"}, rdy_at(4), 1);
  endtask

  typedef struct {
    logic [4:0] addr;
    logic [7:0] ch;
    int         pos;
  } wr_vec_t;

  wr_vec_t vec [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int falls0;

    vec[0] = '{5'd0,  8'h48, 1};
    vec[1] = '{5'd17, 8'h69, 19};
    vec[2] = '{5'd15, 8'h5A, 16};
    vec[3] = '{5'd16, 8'h41, 18};
    vec[4] = '{5'd31, 8'h21, 33};

    bus.iWr      = 1'b0;
    bus.iAddr    = 5'd0;
    bus.iChar    = 8'h00;
    bus.iRefresh = 1'b0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;

    // Reset state.
    rst = 1'b1;
    tick(3);
    chk("rst_start", bus.oLCD_Start, 0);
    chk("rst_ready", bus.oReady, 0);
    chk("rst_busy",  bus.oBusy, 1);
    chk("rst_data",  bus.oLCD_DATA, 0);
    chk("rst_rs",    bus.oLCD_RS, 0);

    // Power-up, init list, automatic first refresh.
    clear_log();
    rst = 1'b0;
    rel = cyc;
    wait_bytes(38, 4000, "t1");
    wait_idle(500, "t1");
    chk_init(rel, "t1");
    chk_stream(4, "t2");
    chk("t2_busy",  bus.oBusy, 0);
    chk("t2_ready", bus.oReady, 1);
    chk("t2_count", got_q.size(), 38);

    // Host writes at the line boundaries, then a refresh from IDLE.
    for (int i = 0; i < 5; i++) begin
      host_write(vec[i].addr, vec[i].ch);
      exp_buf[vec[i].addr] = vec[i].ch;
    end
    clear_log();
    chk("t3_idle_before", bus.oBusy, 0);
    pulse_refresh();
    chk("t3_busy_next", bus.oBusy, 1);
    wait_bytes(34, 2000, "t3");
    wait_idle(500, "t3");
    chk_stream(0, "t3");
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_vec%0d", i), got_at(vec[i].pos), {1'b1, vec[i].ch});

    // Three requests during a refresh collapse to one; a write after its SETUP shows next time.
    clear_log();
    pulse_refresh();
    wait_bytes(7, 1000, "t4_pos6");
    host_write(5'd5, 8'h51);
    for (int i = 0; i < 3; i++) begin
      pulse_refresh();
      tick(5);
    end
    wait_bytes(34, 2000, "t4a");
    chk_stream(0, "t4a");
    exp_buf[5] = 8'h51;
    wait_bytes(68, 2000, "t4b");
    wait_idle(500, "t4");
    chk_stream(34, "t4b");
    tick(100);
    chk("t4_count", got_q.size(), 68);
    chk("t4_busy",  bus.oBusy, 0);

    // Done held high across Start edges.
    clr_at = 4;
    falls0 = falls;
    clear_log();
    pulse_refresh();
    wait_bytes(34, 2000, "t5");
    wait_idle(500, "t5");
    chk_stream(0, "t5");
    chk("t5_hs_viol", hs_viol, 0);
    chk("t5_falls", (falls - falls0) >= 34, 1);
    clr_at = 1;

    // Reset in the middle of byte 10 of a refresh.
    clear_log();
    pulse_refresh();
    wait_bytes(10, 1000, "t6_byte10");
    chk("t6_start_hi", bus.oLCD_Start, 1);
    rst = 1'b1;
    tick(1);
    chk("t6_start", bus.oLCD_Start, 0);
    chk("t6_ready", bus.oReady, 0);
    chk("t6_busy",  bus.oBusy, 1);
    tick(1);
    clear_log();
    rst = 1'b0;
    rel = cyc;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    wait_bytes(38, 4000, "t6");
    wait_idle(500, "t6");
    chk_init(rel, "t6");
    chk_stream(4, "t6r");

    chk("stab_viol", stab_viol, 0);
    chk("hs_viol",   hs_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
